// File: rtl/mips_uc_pkg.sv
// Shared definitions for the MIPS microcontroller peripheral blocks.
// Holds the interrupt controller's register addresses, its FSM state
// encoding and the bit position of ACTIVE.valid.
package mips_uc_pkg;

  // Interrupt controller register map (2-bit address).
  localparam logic [1:0] IC_MASK_ADDR    = 2'd0;
  localparam logic [1:0] IC_PENDING_ADDR = 2'd1;
  localparam logic [1:0] IC_ACTIVE_ADDR  = 2'd2;

  // ACTIVE register layout: valid flag and in-service source id.
  localparam int IC_VALID_BIT = 31;
  localparam int IC_ID_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } ic_state_t;

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (index 0 has the highest priority).
// Ports:
//   req  - request vector
//   any  - at least one bit of req is set
//   idx  - index of the lowest set bit (0 when req is empty)
module priority_encoder
  import mips_uc_pkg::*;
#(
  parameter int NUM_SOURCES = 16
) (
  input  logic [NUM_SOURCES-1:0] req,
  output logic                   any,
  output logic [IC_ID_W-1:0]     idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Scan from the top down so the lowest set bit is written last.
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) idx = IC_ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller. Captures rising edges on the peripheral
// interrupt sources into PENDING, qualifies them with MASK and presents the
// lowest-index candidate to the CPU on irq. The source stays in service
// until software writes ACTIVE (end-of-interrupt).
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   irq_source          - peripheral interrupt levels (rising edge = event)
//   ce, rw, address     - register access strobe, 1=write/0=read, select
//   data_in, data_out   - register write data / combinational read data
//   irq, ack            - request to CPU / acknowledge from CPU
//   dbg_state_o         - current controller state, for observation
//
// Handshake: irq rises when a candidate is latched and stays high (the
// latched id and the request are frozen, mask changes do not withdraw it)
// until ack is sampled high on a rising edge; irq then drops in the same
// edge. ack outside that window is ignored.
module interrupt_controller
  import mips_uc_pkg::*;
#(
  parameter int NUM_SOURCES = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] irq_source,
  input  logic                   ce,
  input  logic                   rw,
  input  logic [1:0]             address,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   irq,
  input  logic                   ack,
  output ic_state_t              dbg_state_o
);

  logic [NUM_SOURCES-1:0] src_q;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [IC_ID_W-1:0]     active_id_q;
  logic                   irq_q;
  ic_state_t              state_q;

  logic                   cand_any;
  logic [IC_ID_W-1:0]     cand_idx;
  logic                   mask_wr, w1c_wr, eoi_wr;
  logic [NUM_SOURCES-1:0] rise, w1c_clr, ack_clr;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   unused_data;

  assign mask_wr = ce && rw && (address == IC_MASK_ADDR);
  assign w1c_wr  = ce && rw && (address == IC_PENDING_ADDR);
  assign eoi_wr  = ce && rw && (address == IC_ACTIVE_ADDR);

  // Only the source-wide slice of the write bus carries meaning.
  assign unused_data = ^data_in[DATA_WIDTH-1:NUM_SOURCES];

  priority_encoder #(.NUM_SOURCES(NUM_SOURCES)) u_prio (
    .req (pending_q & mask_q),
    .any (cand_any),
    .idx (cand_idx)
  );

  always_comb begin
    rise    = irq_source & ~src_q;
    w1c_clr = w1c_wr ? data_in[NUM_SOURCES-1:0] : '0;
    ack_clr = (state_q == ASSERT && ack) ? (NUM_SOURCES'(1) << active_id_q) : '0;
    // A fresh edge wins over any clear landing in the same cycle.
    pending_d = (pending_q & ~w1c_clr & ~ack_clr) | rise;
    mask_d    = mask_wr ? data_in[NUM_SOURCES-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= irq_source;
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      active_id_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_any) begin
            active_id_q <= cand_idx;
            irq_q       <= 1'b1;
            state_q     <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            irq_q   <= 1'b0;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          // active_id is kept after EOI so ACTIVE still reports the last id.
          if (eoi_wr) state_q <= IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (ce) begin
      case (address)
        IC_MASK_ADDR:    rd_data[NUM_SOURCES-1:0] = mask_q;
        IC_PENDING_ADDR: rd_data[NUM_SOURCES-1:0] = pending_q;
        IC_ACTIVE_ADDR: begin
          rd_data[IC_VALID_BIT]  = (state_q == SERVICE);
          rd_data[IC_ID_W-1:0]   = active_id_q;
        end
        default:         rd_data = '0;
      endcase
    end
  end

  assign data_out    = rd_data;
  assign irq         = irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
  import mips_uc_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] irq_source = '0;
  logic        ce = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        irq;
  logic        ack = 1'b0;
  ic_state_t   dbg_state;

  interrupt_controller #(.NUM_SOURCES(16), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_source  (irq_source),
    .ce          (ce),
    .rw          (rw),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .irq         (irq),
    .ack         (ack),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ce = 1'b1; rw = 1'b1; address = a; data_in = d;
    tick();
    ce = 1'b0; rw = 1'b0; data_in = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ce = 1'b1; rw = 1'b0; address = a;
    exp_q.push_back(exp);
    #1;
    check(tag, data_out);
    ce = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    exp_q.push_back({31'd0, exp});
    check(tag, {31'd0, irq});
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic eoi();
    wr(IC_ACTIVE_ADDR, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(); tick();
    rst = 1'b1;
    #1;
    irq_chk("por_irq", 1'b0);
    rd_chk("por_mask", IC_MASK_ADDR, 32'h0);
    rd_chk("por_pend", IC_PENDING_ADDR, 32'h0);
    rd_chk("por_active", IC_ACTIVE_ADDR, 32'h0);
    exp_q.push_back(32'h0);
    check("ce0_dout", data_out);

    // Basic handshake on source 1 with MASK=3.
    wr(IC_MASK_ADDR, 32'h3);
    irq_source[1] = 1'b1;
    tick();
    irq_chk("basic_irq_k", 1'b0);
    rd_chk("basic_pend_k", IC_PENDING_ADDR, 32'h2);
    tick();
    irq_chk("basic_irq_k1", 1'b1);
    rd_chk("basic_active_assert", IC_ACTIVE_ADDR, 32'h1);
    do_ack();
    irq_chk("basic_irq_ack", 1'b0);
    rd_chk("basic_active_svc", IC_ACTIVE_ADDR, 32'h8000_0001);
    rd_chk("basic_pend_svc", IC_PENDING_ADDR, 32'h0);
    eoi();
    rd_chk("basic_active_eoi", IC_ACTIVE_ADDR, 32'h1);
    irq_source[1] = 1'b0;
    tick();

    // Reset in the middle of ASSERT.
    irq_source[1] = 1'b1;
    tick(); tick();
    irq_chk("rst_pre_irq", 1'b1);
    rst = 1'b0;
    #1;
    irq_chk("rst_async_irq", 1'b0);
    irq_source = '0;
    tick();
    rst = 1'b1;
    #1;
    rd_chk("rst_mask", IC_MASK_ADDR, 32'h0);
    rd_chk("rst_pend", IC_PENDING_ADDR, 32'h0);
    rd_chk("rst_active", IC_ACTIVE_ADDR, 32'h0);

    // Priority: sources 0 and 1 together.
    wr(IC_MASK_ADDR, 32'h3);
    irq_source[1:0] = 2'b11;
    tick(); tick();
    irq_chk("prio_irq0", 1'b1);
    rd_chk("prio_active0", IC_ACTIVE_ADDR, 32'h0);
    do_ack();
    rd_chk("prio_active0_svc", IC_ACTIVE_ADDR, 32'h8000_0000);
    rd_chk("prio_pend_left", IC_PENDING_ADDR, 32'h2);
    eoi();
    irq_chk("prio_irq_eoi", 1'b0);
    tick();
    irq_chk("prio_irq1", 1'b1);
    rd_chk("prio_active1", IC_ACTIVE_ADDR, 32'h1);
    do_ack();
    eoi();
    irq_source = '0;
    tick();

    // Masking.
    wr(IC_MASK_ADDR, 32'h0);
    irq_source[1] = 1'b1;
    tick(); tick();
    irq_chk("mask_irq_off", 1'b0);
    rd_chk("mask_pend", IC_PENDING_ADDR, 32'h2);
    wr(IC_MASK_ADDR, 32'hFFFF_0002);
    rd_chk("mask_readback", IC_MASK_ADDR, 32'h2);
    irq_chk("mask_irq_wr", 1'b0);
    tick();
    irq_chk("mask_irq_on", 1'b1);
    do_ack();
    eoi();
    irq_source = '0;
    tick();

    // W1C against a same-cycle set (source 0 masked, MASK=2).
    ce = 1'b1; rw = 1'b1; address = IC_PENDING_ADDR; data_in = 32'h1;
    irq_source[0] = 1'b1;
    tick();
    ce = 1'b0; rw = 1'b0; data_in = '0;
    rd_chk("w1c_set_wins", IC_PENDING_ADDR, 32'h1);
    wr(IC_PENDING_ADDR, 32'h1);
    rd_chk("w1c_clear", IC_PENDING_ADDR, 32'h0);

    // Held level: one service only; EOI during ASSERT ignored.
    irq_source[0] = 1'b0;
    tick();
    wr(IC_MASK_ADDR, 32'h1);
    irq_source[0] = 1'b1;
    tick(); tick();
    irq_chk("held_irq", 1'b1);
    eoi();
    irq_chk("eoi_in_assert", 1'b1);
    do_ack();
    eoi();
    tick(); tick(); tick();
    irq_chk("held_no_retrig", 1'b0);
    rd_chk("held_pend", IC_PENDING_ADDR, 32'h0);

    // Re-trigger during SERVICE.
    irq_source[0] = 1'b0;
    tick();
    irq_source[0] = 1'b1;
    tick(); tick();
    irq_chk("retrig_irq", 1'b1);
    do_ack();
    irq_source[0] = 1'b0;
    tick();
    irq_source[0] = 1'b1;
    tick();
    rd_chk("retrig_pend", IC_PENDING_ADDR, 32'h1);
    irq_chk("retrig_svc_irq", 1'b0);
    eoi();
    irq_chk("retrig_eoi_irq", 1'b0);
    tick();
    irq_chk("retrig_again", 1'b1);
    do_ack();
    eoi();
    irq_source = '0;
    tick();

    // Stray ack in IDLE with a masked pending source.
    irq_source[1] = 1'b1;
    tick();
    do_ack();
    tick();
    irq_chk("stray_ack_irq", 1'b0);
    rd_chk("stray_ack_pend", IC_PENDING_ADDR, 32'h2);
    rd_chk("stray_ack_active", IC_ACTIVE_ADDR, 32'h0);
    rd_chk("reserved_rd", 2'd3, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Priority interrupt controller for the MIPS microcontroller's peripheral bus. It latches rising edges on up to 16 peripheral interrupt sources (port I/O, timer, …) and masks them, then presents the highest-priority request to the CPU as a single `irq` line. It closes the `irq`/`ack` handshake and holds the in-service source until software issues end-of-interrupt. It occupies one peripheral slot behind the address decoder and is programmed through memory-mapped registers.

## Interface
- `NUM_SOURCES`, 16, number of interrupt inputs (1–16); index 0 has the highest priority.
- `DATA_WIDTH`, 32, width of the register read/write bus.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `irq_source`  in  NUM_SOURCES  level inputs from peripherals; a rising edge is the event.
- `ce`  in  1  register access enable, from the decoder chip-select.
- `rw`  in  1  1 = write, 0 = read.
- `address`  in  2  register select.
- `data_in`  in  DATA_WIDTH  write data from the CPU.
- `data_out`  out  DATA_WIDTH  read data, combinational from registers; 0 when `ce`=0.
- `irq`  out  1  interrupt request to the CPU, registered.
- `ack`  in  1  CPU interrupt acknowledge, one or more cycles wide.

## Operation
Register map:
- Address 0, MASK: read/write; bit i=1 enables source i; bits ≥ NUM_SOURCES read 0.
- Address 1, PENDING: read; writing 1 to a bit clears it (write-1-to-clear).
- Address 2, ACTIVE: read gives {valid in bit 31, id in bits 3:0}; any write is end-of-interrupt (EOI).
- Address 3: reserved; reads 0, writes are ignored.

Edge capture and pending:
- `src_q` holds the previous `irq_source`.
- `pending[i]` is set when `irq_source[i] & ~src_q[i]`.
- Set has priority over a same-cycle W1C clear.
- Masked sources still set pending, but are not candidates.

Candidate selection:
- Candidate set is `pending & mask`.
- Selection is fixed priority, lowest index wins.

FSM states: IDLE, ASSERT, SERVICE.
- IDLE: if any candidate exists, latch `active_id` = winner, go to ASSERT.
- ASSERT: `irq`=1. `active_id` is frozen, and later mask changes do not retract the request. When `ack`=1, clear `pending[active_id]` and go to SERVICE.
- SERVICE: `irq`=0, ACTIVE.valid=1. An EOI write goes to IDLE and sets valid to 0.

Other rules:
- `ack` in IDLE or SERVICE is ignored.
- An EOI write outside SERVICE is ignored.
- A new edge on the in-service source during SERVICE sets pending again; it is serviced after EOI.

## Timing
- Reset values: `irq`=0, `data_out`=0 (`ce`=0), mask=0, pending=0, `src_q`=0, `active_id`=0, state IDLE.
- Reset mid-ASSERT or mid-SERVICE aborts immediately to these values.
- Source sampled high at rising edge k with `src_q`=0: pending is set after edge k. With the mask enabled, state becomes ASSERT and `irq`=1 after edge k+1, a 2-cycle latency.
- `ack` sampled high at edge m: `irq`=0 and pending cleared after edge m.
- EOI at edge e: IDLE after edge e. If a candidate is waiting, `irq` rises again after edge e+1.
- A level held high generates exactly one event; it must fall and rise again to re-trigger.
- MASK write and edge capture in the same cycle: the new mask governs selection from the next cycle.

## Structure
- Package `mips_uc_pkg` holds:
  - register address constants `IC_MASK_ADDR`, `IC_PENDING_ADDR`, `IC_ACTIVE_ADDR`;
  - the state enum `ic_state_t` (IDLE, ASSERT, SERVICE);
  - `IC_VALID_BIT` = 31.
- One sub-module, `priority_encoder`: purely combinational; NUM_SOURCES-bit vector in, {any, 4-bit index of the lowest set bit} out.

## Test plan
- Reset: `rst`=0 mid-ASSERT → `irq`=0 immediately; after release, reads of MASK, PENDING and ACTIVE all return 0.
- Basic handshake, MASK=0x0003:
  - timer source 1 rises → `irq`=1 two cycles later, ACTIVE read = 0x00000001 with valid=0.
  - `ack` → `irq`=0, ACTIVE = 0x80000001, PENDING = 0.
  - EOI → ACTIVE = 0x00000001, valid=0.
- Priority: sources 0 and 1 rise in the same cycle, MASK=0x0003:
  - id 0 is serviced first.
  - after `ack` and EOI, `irq` reasserts one cycle after EOI with id 1.
- Masking: MASK=0, source 1 rises → PENDING = 0x0002 and `irq` stays 0. Writing MASK = 0x0002 → `irq`=1 two cycles later.
- W1C vs set: write PENDING = 0x0001 in the same cycle source 0 rises → PENDING bit 0 stays 1. A later W1C alone clears it.
- Re-trigger and held level:
  - source 0 held high → only one service.
  - source 0 toggled during SERVICE → pending re-set, `irq` reasserts after EOI.
  - stray `ack` in IDLE → no state change.
